bus_slot_scheduler: RTL



---
 rtl/bus_slot_scheduler_if.sv | 59 +++++
 rtl/bus_slot_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bus_slot_scheduler_if.sv
// Bus/requester signal bundle for bus_slot_scheduler.
// slave: the scheduler side. master: the requesters, CPU pins and SRAM side.
interface bus_slot_scheduler_if;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;

  // Video fetcher
  logic              video_req_i;
  logic [ADDR_W-1:0] video_addr_i;
  logic              video_done_o;
  logic [DATA_W-1:0] video_data_o;

  // MCU SPI bridge
  logic              mcu_req_i;
  logic              mcu_we_i;
  logic [ADDR_W-1:0] mcu_addr_i;
  logic [DATA_W-1:0] mcu_wdata_i;
  logic              mcu_done_o;
  logic [DATA_W-1:0] mcu_rdata_o;

  // Shared bus pins and SRAM strobes
  logic              bus_rw_ni;
  logic [DATA_W-1:0] bus_data_i;
  logic [ADDR_W-1:0] bus_addr_o;
  logic              bus_addr_oe;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_data_oe;
  logic              bus_rw_no;
  logic              bus_rw_noe;
  logic              ram_oe_no;
  logic              ram_we_no;

  // CPU timing
  logic              cpu_be_o;
  logic              cpu_clk_o;
  logic              frame_o;

  modport slave (
    input  video_req_i, video_addr_i,
    input  mcu_req_i, mcu_we_i, mcu_addr_i, mcu_wdata_i,
    input  bus_rw_ni, bus_data_i,
    output video_done_o, video_data_o,
    output mcu_done_o, mcu_rdata_o,
    output bus_addr_o, bus_addr_oe, bus_data_o, bus_data_oe,
    output bus_rw_no, bus_rw_noe, ram_oe_no, ram_we_no,
    output cpu_be_o, cpu_clk_o, frame_o
  );

  modport master (
    output video_req_i, video_addr_i,
    output mcu_req_i, mcu_we_i, mcu_addr_i, mcu_wdata_i,
    output bus_rw_ni, bus_data_i,
    input  video_done_o, video_data_o,
    input  mcu_done_o, mcu_rdata_o,
    input  bus_addr_o, bus_addr_oe, bus_data_o, bus_data_oe,
    input  bus_rw_no, bus_rw_noe, ram_oe_no, ram_we_no,
    input  cpu_be_o, cpu_clk_o, frame_o
  );
endinterface

// File: rtl/bus_slot_scheduler.sv
// Time-division scheduler for the shared address/data bus and SRAM.
// 16-cycle frames: cycles 0-5 one video/MCU access, cycle 6 turnaround,
// then the CPU slot. All outputs are registered from the next-cycle decode.
// Optional feature macro: BUS_SLOT_FAIRNESS_EN (an MCU that lost to video
// wins the following arbitration). Undefined: fixed video priority.
module bus_slot_scheduler #(
  parameter int unsigned CPU_BE_START = 7,
  parameter int unsigned PHI2_START   = 12
) (
  input  logic                clk16_i,
  input  logic                reset_i,
  bus_slot_scheduler_if.slave bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] CYC_FIRST    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CYC_STRB_S   = CNT_W'(1);   // read OE / write data start
  localparam logic [CNT_W-1:0] CYC_WE_S     = CNT_W'(2);
  localparam logic [CNT_W-1:0] CYC_CAPTURE  = CNT_W'(4);   // last strobe cycle, data sampled at its end
  localparam logic [CNT_W-1:0] CYC_WIN_END  = CNT_W'(5);   // last driven cycle, done pulse
  localparam logic [CNT_W-1:0] CYC_TURN     = CNT_W'(6);
  localparam logic [CNT_W-1:0] CYC_LAST     = CNT_W'(15);
  localparam logic [CNT_W-1:0] CYC_BE       = CNT_W'(CPU_BE_START);
  localparam logic [CNT_W-1:0] CYC_PHI2     = CNT_W'(PHI2_START);
  localparam logic [CNT_W-1:0] CYC_RW_SMP   = CNT_W'(PHI2_START - 1);
  localparam logic [CNT_W-1:0] CYC_CPU_WE_S = CNT_W'(PHI2_START + 1);
  localparam logic [CNT_W-1:0] CYC_CPU_WE_E = CNT_W'(14);

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_VIDEO = 2'd1,
    GNT_MCU   = 2'd2
  } grant_t;

  logic [CNT_W-1:0]  r_cnt;
  grant_t            r_grant;
  logic              r_cpu_rw;

  logic [CNT_W-1:0]  w_cnt_nxt;
  grant_t            w_grant_arb;
  grant_t            w_grant_nxt;
  logic              w_cpu_rw_nxt;
  logic              w_act;
  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic              w_data_oe;
  logic              w_ram_oe;
  logic              w_ram_we;

`ifdef BUS_SLOT_FAIRNESS_EN
  logic              r_starve;
  logic              w_starve_nxt;

  // Arbitration with starvation override: a starved MCU beats video once
  always_comb begin
    w_grant_arb  = GNT_NONE;
    w_starve_nxt = r_starve;
    if (bus.mcu_req_i && (r_starve || !bus.video_req_i)) begin
      w_grant_arb  = GNT_MCU;
      w_starve_nxt = 1'b0;
    end else if (bus.video_req_i) begin
      w_grant_arb  = GNT_VIDEO;
      w_starve_nxt = bus.mcu_req_i;
    end
  end

  // Starvation flag updates only at the arbitration edge
  always_ff @(posedge clk16_i) begin
    if (reset_i) begin
      r_starve <= 1'b0;
    end else if (r_cnt == CYC_LAST) begin
      r_starve <= w_starve_nxt;
    end
  end
`else
  // Arbitration with fixed video priority
  always_comb begin
    w_grant_arb = GNT_NONE;
    if (bus.video_req_i) begin
      w_grant_arb = GNT_VIDEO;
    end else if (bus.mcu_req_i) begin
      w_grant_arb = GNT_MCU;
    end
  end
`endif

  // Decode what the next cycle looks like so every output can be registered
  always_comb begin
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_grant_nxt = r_grant;
    if (r_cnt == CYC_LAST) begin
      w_grant_nxt = w_grant_arb;
    end else if (r_cnt == CYC_TURN) begin
      w_grant_nxt = GNT_NONE;
    end
    w_cpu_rw_nxt = (r_cnt == CYC_RW_SMP) ? bus.bus_rw_ni : r_cpu_rw;

    w_act  = (w_grant_nxt != GNT_NONE) && (w_cnt_nxt <= CYC_WIN_END);
    w_wr   = (w_grant_nxt == GNT_MCU) && bus.mcu_we_i;
    w_rd   = (w_grant_nxt != GNT_NONE) && !w_wr;
    w_addr = (w_grant_nxt == GNT_MCU) ? bus.mcu_addr_i : bus.video_addr_i;

    w_data_oe = w_wr && (w_cnt_nxt >= CYC_STRB_S) && (w_cnt_nxt <= CYC_WIN_END);
    w_ram_oe  = (w_rd && (w_cnt_nxt >= CYC_STRB_S) && (w_cnt_nxt <= CYC_CAPTURE)) ||
                (w_cpu_rw_nxt && (w_cnt_nxt >= CYC_PHI2));
    w_ram_we  = (w_wr && (w_cnt_nxt >= CYC_WE_S) && (w_cnt_nxt <= CYC_CAPTURE)) ||
                (!w_cpu_rw_nxt && (w_cnt_nxt >= CYC_CPU_WE_S) && (w_cnt_nxt <= CYC_CPU_WE_E));
  end

  // Frame state, grant and all registered outputs
  always_ff @(posedge clk16_i) begin
    if (reset_i) begin
      r_cnt            <= CYC_LAST;
      r_grant          <= GNT_NONE;
      r_cpu_rw         <= 1'b1;
      bus.frame_o      <= 1'b0;
      bus.cpu_be_o     <= 1'b0;
      bus.cpu_clk_o    <= 1'b0;
      bus.bus_addr_oe  <= 1'b0;
      bus.bus_addr_o   <= '0;
      bus.bus_rw_noe   <= 1'b0;
      bus.bus_rw_no    <= 1'b1;
      bus.bus_data_oe  <= 1'b0;
      bus.bus_data_o   <= '0;
      bus.ram_oe_no    <= 1'b1;
      bus.ram_we_no    <= 1'b1;
      bus.video_done_o <= 1'b0;
      bus.mcu_done_o   <= 1'b0;
      bus.video_data_o <= '0;
      bus.mcu_rdata_o  <= '0;
    end else begin
      r_cnt            <= w_cnt_nxt;
      r_grant          <= w_grant_nxt;
      r_cpu_rw         <= w_cpu_rw_nxt;
      bus.frame_o      <= (w_cnt_nxt == CYC_FIRST);
      bus.cpu_be_o     <= (w_cnt_nxt >= CYC_BE);
      bus.cpu_clk_o    <= (w_cnt_nxt >= CYC_PHI2);
      bus.bus_addr_oe  <= w_act;
      bus.bus_addr_o   <= w_act ? w_addr : ADDR_W'(0);
      bus.bus_rw_noe   <= w_act;
      bus.bus_rw_no    <= !(w_act && w_wr);
      bus.bus_data_oe  <= w_data_oe;
      bus.bus_data_o   <= w_data_oe ? bus.mcu_wdata_i : DATA_W'(0);
      bus.ram_oe_no    <= !w_ram_oe;
      bus.ram_we_no    <= !w_ram_we;
      bus.video_done_o <= (w_grant_nxt == GNT_VIDEO) && (w_cnt_nxt == CYC_WIN_END);
      bus.mcu_done_o   <= (w_grant_nxt == GNT_MCU) && (w_cnt_nxt == CYC_WIN_END);
      if ((r_cnt == CYC_CAPTURE) && (r_grant == GNT_VIDEO)) begin
        bus.video_data_o <= bus.bus_data_i;
      end
      if ((r_cnt == CYC_CAPTURE) && (r_grant == GNT_MCU) && !bus.mcu_we_i) begin
        bus.mcu_rdata_o <= bus.bus_data_i;
      end
    end
  end
endmodule
